// File: rtl/updown_ctrl_debounce.sv
// updown_ctrl_debounce: debounces DIR/RUN buttons and drives count_up plus a prescaled step strobe
module updown_ctrl_debounce #(
  parameter int DEB_CYCLES = 500_000,
  parameter int PRESCALE   = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_dir,
  input  logic btn_run,
  output logic count_up,
  output logic step,
  output logic running,
  output logic dir_pulse,
  output logic run_pulse
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(PRESCALE);
  typedef enum logic [1:0] {IDLE, CHECK_PRESS, HELD, CHECK_RELEASE} deb_t;
  logic [1:0] btn, meta, sync, accept;
  logic [PW-1:0] pc;
  logic wrap;
  assign btn = {btn_run, btn_dir};
  assign wrap = pc == PW'(PRESCALE - 1);
  always_ff @(posedge clk)
    if (!reset) {sync, meta} <= '0;
    else {sync, meta} <= {meta, btn};
  // bit 0 debounces DIR, bit 1 debounces RUN
  for (genvar b = 0; b < 2; b++) begin : g_deb
    deb_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic done, acc;
    assign done = cnt == CW'(DEB_CYCLES);
    assign accept[b] = acc;
    always_ff @(posedge clk)
      if (!reset) begin
        state <= IDLE;
        cnt <= '0;
      end else begin
        state <= state_nx;
        cnt <= cnt_nx;
      end
    always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      acc = 1'b0;
      case (state)
        IDLE: if (sync[b]) begin
          state_nx = CHECK_PRESS;
          cnt_nx = CW'(1);
        end
        CHECK_PRESS: if (!sync[b]) begin
          state_nx = IDLE;
          cnt_nx = '0;
        end else if (done) begin
          state_nx = HELD;
          cnt_nx = '0;
          acc = 1'b1;
        end else cnt_nx = cnt + 1'b1;
        HELD: if (!sync[b]) begin
          state_nx = CHECK_RELEASE;
          cnt_nx = CW'(1);
        end
        CHECK_RELEASE: if (sync[b]) begin
          state_nx = HELD;
          cnt_nx = '0;
        end else if (done) begin
          state_nx = IDLE;
          cnt_nx = '0;
        end else cnt_nx = cnt + 1'b1;
        default: begin
          state_nx = IDLE;
          cnt_nx = '0;
        end
      endcase
    end
  end
  // pc advances on the pausing edge itself; only the step it would produce is dropped
  always_ff @(posedge clk)
    if (!reset) begin
      count_up <= 1'b1;
      running <= 1'b1;
      step <= 1'b0;
      dir_pulse <= 1'b0;
      run_pulse <= 1'b0;
      pc <= '0;
    end else begin
      count_up <= count_up ^ accept[0];
      running <= running ^ accept[1];
      dir_pulse <= accept[0];
      run_pulse <= accept[1];
      step <= running & ~accept[1] & wrap;
      if (running) pc <= wrap ? '0 : pc + 1'b1;
    end
endmodule
